hbridge_pwm_ctrl: RTL and testbench

Parametrised multi-channel H-bridge driver for TB6612-class motor drivers. It is the successor of the single-channel controller. Each channel runs its own direction state machine with an enforced coast dead-time on reversal and a short-brake mode. PWM width, prescaler, soft-start ramp and pause duration are parameters. It sits between the application/command logic and the driver pins (IN1/IN2/PWM per channel, shared STBY).

---
 rtl/hbridge_pwm_ctrl_if.sv | 29 ++
 rtl/hbridge_pwm_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_hbridge_pwm_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hbridge_pwm_ctrl_if.sv
// Command/driver-pin bundle between application logic and the H-bridge controller.
// Latency: none (wires only).
// Backpressure: none; commands are levels sampled every clk.
interface hbridge_pwm_ctrl_if #(
    parameter int N_CH  = 2,
    parameter int PWM_W = 8
);
    logic                    enable;
    logic [2*N_CH-1:0]       dir_cmd;
    logic [PWM_W*N_CH-1:0]   duty_cmd;
    logic                    pause;
    logic [N_CH-1:0]         in1;
    logic [N_CH-1:0]         in2;
    logic [N_CH-1:0]         pwm;
    logic                    stby;
    logic                    paused;

    // Command side: drives enable/direction/duty/pause, observes the pins.
    modport master (
        output enable, dir_cmd, duty_cmd, pause,
        input  in1, in2, pwm, stby, paused
    );

    // Controller side.
    modport slave (
        input  enable, dir_cmd, duty_cmd, pause,
        output in1, in2, pwm, stby, paused
    );
endinterface

// File: rtl/hbridge_pwm_ctrl.sv
// Multi-channel H-bridge driver: per-channel direction FSM with reversal dead-time, brake, soft-start PWM, global pause.
// Latency: dir_cmd/enable take effect one edge after sampling; pause edge coasts the outputs two edges after sampling.
// Backpressure: none; all outputs decode from registers only, rst clears them asynchronously.
module hbridge_pwm_ctrl #(
    parameter int N_CH      = 2,
    parameter int PWM_W     = 8,
    parameter int PRESC     = 4096,
    parameter int DEAD_CYC  = 50_000,
    parameter int RAMP_STEP = 1,
    parameter int PAUSE_CYC = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    hbridge_pwm_ctrl_if.slave bus
);

    localparam int PRESC_W = (PRESC > 1)     ? $clog2(PRESC)     : 1;
    localparam int DEAD_W  = (DEAD_CYC > 1)  ? $clog2(DEAD_CYC)  : 1;
    localparam int PAUSE_W = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN_CW,
        ST_RUN_CCW,
        ST_DEAD,
        ST_BRAKE
    } state_e;

    state_e             state_q  [N_CH];
    state_e             state_d  [N_CH];
    logic [DEAD_W-1:0]  dead_q   [N_CH];
    logic [DEAD_W-1:0]  dead_d   [N_CH];
    logic [PWM_W-1:0]   duty_q   [N_CH];
    logic [PWM_W-1:0]   duty_d   [N_CH];
    logic [PWM_W:0]     ramp_sum [N_CH];

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PWM_W-1:0]   cnt_q, cnt_d;
    logic               presc_tc;
    logic               boundary;

    logic               pause_q;
    logic               rise_q;
    logic               paused_q, paused_d;
    logic [PAUSE_W-1:0] pcnt_q, pcnt_d;
    logic               stby_q;

    logic [N_CH-1:0]    in1_w, in2_w, pwm_w;

    // Shared PWM timebase and the pause window (one-shot, no retrigger while active).
    always_comb begin
        presc_tc = (presc_q == PRESC_W'(PRESC - 1));
        presc_d  = presc_tc ? '0 : presc_q + 1'b1;
        cnt_d    = presc_tc ? cnt_q + 1'b1 : cnt_q;
        boundary = presc_tc && (cnt_q == '1);
        paused_d = paused_q;
        pcnt_d   = pcnt_q;
        if (paused_q) begin
            if (pcnt_q == '0) begin
                paused_d = 1'b0;
            end else begin
                pcnt_d = pcnt_q - 1'b1;
            end
        end else if (rise_q) begin
            paused_d = 1'b1;
            pcnt_d   = PAUSE_W'(PAUSE_CYC - 1);
        end
    end

    // Per-channel direction FSM next state, dead-time countdown and duty ramp.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            dead_d[i]   = dead_q[i];
            duty_d[i]   = '0;
            ramp_sum[i] = {1'b0, duty_q[i]} + (PWM_W+1)'(RAMP_STEP);
            case (state_q[i])
                ST_IDLE: begin
                    case (bus.dir_cmd[2*i +: 2])
                        2'b01:   state_d[i] = ST_RUN_CW;
                        2'b10:   state_d[i] = ST_RUN_CCW;
                        2'b11:   state_d[i] = ST_BRAKE;
                        default: state_d[i] = ST_IDLE;
                    endcase
                end
                ST_RUN_CW, ST_RUN_CCW: begin
                    case (bus.dir_cmd[2*i +: 2])
                        2'b00:   state_d[i] = ST_IDLE;
                        2'b11:   state_d[i] = ST_BRAKE;
                        2'b01: begin
                            if (state_q[i] == ST_RUN_CCW) begin
                                state_d[i] = ST_DEAD;
                                dead_d[i]  = DEAD_W'(DEAD_CYC - 1);
                            end
                        end
                        default: begin
                            if (state_q[i] == ST_RUN_CW) begin
                                state_d[i] = ST_DEAD;
                                dead_d[i]  = DEAD_W'(DEAD_CYC - 1);
                            end
                        end
                    endcase
                end
                ST_DEAD: begin
                    // Stop and brake cut the dead-time short; a CW/CCW flip keeps counting.
                    if (bus.dir_cmd[2*i +: 2] == 2'b00) begin
                        state_d[i] = ST_IDLE;
                    end else if (bus.dir_cmd[2*i +: 2] == 2'b11) begin
                        state_d[i] = ST_BRAKE;
                    end else if (dead_q[i] == '0) begin
                        state_d[i] = (bus.dir_cmd[2*i +: 2] == 2'b01) ? ST_RUN_CW : ST_RUN_CCW;
                    end else begin
                        dead_d[i] = dead_q[i] - 1'b1;
                    end
                end
                ST_BRAKE: begin
                    case (bus.dir_cmd[2*i +: 2])
                        2'b00:   state_d[i] = ST_IDLE;
                        2'b01:   state_d[i] = ST_RUN_CW;
                        2'b10:   state_d[i] = ST_RUN_CCW;
                        default: state_d[i] = ST_BRAKE;
                    endcase
                end
                default: state_d[i] = ST_IDLE;
            endcase
            // Pause overrides any command decided on the same edge.
            if (paused_d) begin
                state_d[i] = ST_IDLE;
            end
            // Duty only survives while staying in the same run state; any exit restarts the ramp from 0.
            if ((state_q[i] == ST_RUN_CW || state_q[i] == ST_RUN_CCW) && state_d[i] == state_q[i]) begin
                if (RAMP_STEP == 0) begin
                    duty_d[i] = bus.duty_cmd[PWM_W*i +: PWM_W];
                end else if (bus.duty_cmd[PWM_W*i +: PWM_W] < duty_q[i]) begin
                    duty_d[i] = bus.duty_cmd[PWM_W*i +: PWM_W];
                end else if (boundary) begin
                    if (ramp_sum[i] > {1'b0, bus.duty_cmd[PWM_W*i +: PWM_W]}) begin
                        duty_d[i] = bus.duty_cmd[PWM_W*i +: PWM_W];
                    end else begin
                        duty_d[i] = ramp_sum[i][PWM_W-1:0];
                    end
                end else begin
                    duty_d[i] = duty_q[i];
                end
            end
        end
    end

    // Pin decode from registered state; coast in IDLE/DEAD.
    always_comb begin
        in1_w = '0;
        in2_w = '0;
        pwm_w = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (state_q[i])
                ST_RUN_CW: begin
                    in1_w[i] = 1'b1;
                    pwm_w[i] = (cnt_q < duty_q[i]);
                end
                ST_RUN_CCW: begin
                    in2_w[i] = 1'b1;
                    pwm_w[i] = (cnt_q < duty_q[i]);
                end
                ST_BRAKE: begin
                    in1_w[i] = 1'b1;
                    in2_w[i] = 1'b1;
                    pwm_w[i] = 1'b1;
                end
                default: begin
                    in1_w[i] = 1'b0;
                    in2_w[i] = 1'b0;
                    pwm_w[i] = 1'b0;
                end
            endcase
        end
    end

    // State registers; rst clears everything without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            pause_q  <= 1'b0;
            rise_q   <= 1'b0;
            paused_q <= 1'b0;
            pcnt_q   <= '0;
            stby_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_IDLE;
                dead_q[i]  <= '0;
                duty_q[i]  <= '0;
            end
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            pause_q  <= bus.pause;
            rise_q   <= bus.pause & ~pause_q;
            paused_q <= paused_d;
            pcnt_q   <= pcnt_d;
            stby_q   <= bus.enable;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                dead_q[i]  <= dead_d[i];
                duty_q[i]  <= duty_d[i];
            end
        end
    end

    assign bus.in1    = in1_w;
    assign bus.in2    = in2_w;
    assign bus.pwm    = pwm_w;
    assign bus.stby   = stby_q;
    assign bus.paused = paused_q;

endmodule

// File: tb/tb_hbridge_pwm_ctrl.sv
// Bench for hbridge_pwm_ctrl: directed scenarios plus random commands against a behavioural model.
// Latency: model advances on each posedge, pins compared on the following negedge.
// Backpressure: none.
module tb_hbridge_pwm_ctrl;

    localparam int N_CH      = 2;
    localparam int PWM_W     = 4;
    localparam int PRESC     = 2;
    localparam int DEAD_CYC  = 8;
    localparam int RAMP_STEP = 4;
    localparam int PAUSE_CYC = 20;
    localparam int STEPS     = 1 << PWM_W;
    localparam int PERIOD    = PRESC * STEPS;

    localparam byte M_STOP  = "S";
    localparam byte M_FWD   = "F";
    localparam byte M_REV   = "R";
    localparam byte M_COAST = "C";
    localparam byte M_BRK   = "B";

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hbridge_pwm_ctrl_if #(.N_CH(N_CH), .PWM_W(PWM_W)) bus ();

    hbridge_pwm_ctrl #(
        .N_CH(N_CH), .PWM_W(PWM_W), .PRESC(PRESC), .DEAD_CYC(DEAD_CYC),
        .RAMP_STEP(RAMP_STEP), .PAUSE_CYC(PAUSE_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference: edges counted since reset release, modes as letters.
    int  edges;
    byte mode       [N_CH];
    int  eff        [N_CH];
    int  dead_start [N_CH];
    int  last_rise;
    int  pause_start;
    bit  prev_p;
    bit  m_stby;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit paused_after(input int e);
        return (e >= pause_start) && (e < pause_start + PAUSE_CYC);
    endfunction

    task automatic model_reset();
        edges       = 0;
        last_rise   = -100;
        pause_start = -100000;
        prev_p      = 1'b0;
        m_stby      = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            mode[i]       = M_STOP;
            eff[i]        = 0;
            dead_start[i] = 0;
        end
    endtask

    task automatic model_edge();
        int  e;
        int  cmd;
        int  dc;
        byte old;
        byte nm;
        bit  bnd;
        bit  force_stop;
        e   = edges + 1;
        bnd = (e % PERIOD) == 0;
        if (!paused_after(e - 1) && last_rise == e - 1) pause_start = e;
        if (bus.pause && !prev_p) last_rise = e;
        prev_p     = bus.pause;
        force_stop = paused_after(e);
        for (int i = 0; i < N_CH; i++) begin
            cmd = int'(bus.dir_cmd[2*i +: 2]);
            dc  = int'(bus.duty_cmd[PWM_W*i +: PWM_W]);
            old = mode[i];
            nm  = old;
            if (old == M_STOP) begin
                nm = (cmd == 1) ? M_FWD : (cmd == 2) ? M_REV : (cmd == 3) ? M_BRK : M_STOP;
            end else if (old == M_FWD || old == M_REV) begin
                if (cmd == 0) nm = M_STOP;
                else if (cmd == 3) nm = M_BRK;
                else if ((cmd == 2 && old == M_FWD) || (cmd == 1 && old == M_REV)) begin
                    nm = M_COAST;
                    dead_start[i] = e;
                end
            end else if (old == M_COAST) begin
                if (cmd == 0) nm = M_STOP;
                else if (cmd == 3) nm = M_BRK;
                else if (e - dead_start[i] >= DEAD_CYC) nm = (cmd == 1) ? M_FWD : M_REV;
            end else begin
                nm = (cmd == 0) ? M_STOP : (cmd == 1) ? M_FWD : (cmd == 2) ? M_REV : M_BRK;
            end
            if (force_stop) nm = M_STOP;
            if ((old == M_FWD || old == M_REV) && nm == old) begin
                if (dc < eff[i]) eff[i] = dc;
                else if (bnd) eff[i] = (eff[i] + RAMP_STEP > dc) ? dc : eff[i] + RAMP_STEP;
            end else begin
                eff[i] = 0;
            end
            mode[i] = nm;
        end
        m_stby = bus.enable;
        edges  = e;
    endtask

    task automatic compare();
        logic [N_CH-1:0] e1, e2, ep;
        int cnt;
        cnt = (edges / PRESC) % STEPS;
        e1 = '0; e2 = '0; ep = '0;
        for (int i = 0; i < N_CH; i++) begin
            e1[i] = (mode[i] == M_FWD) || (mode[i] == M_BRK);
            e2[i] = (mode[i] == M_REV) || (mode[i] == M_BRK);
            ep[i] = (mode[i] == M_BRK) || ((mode[i] == M_FWD || mode[i] == M_REV) && cnt < eff[i]);
        end
        chk("in1", int'(bus.in1), int'(e1));
        chk("in2", int'(bus.in2), int'(e2));
        chk("pwm", int'(bus.pwm), int'(ep));
        chk("stby", int'(bus.stby), int'(m_stby));
        chk("paused", int'(bus.paused), int'(paused_after(edges)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic set_ch(input int ch, input int cmd, input int duty);
        bus.dir_cmd[2*ch +: 2]          = 2'(cmd);
        bus.duty_cmd[PWM_W*ch +: PWM_W] = PWM_W'(duty);
    endtask

    initial begin
        int n;
        int hi;
        bit found;
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.dir_cmd  = '0;
        bus.duty_cmd = '0;
        bus.pause    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_in1", int'(bus.in1), 0);
        chk("rst_pwm", int'(bus.pwm), 0);
        chk("rst_stby", int'(bus.stby), 0);
        chk("rst_paused", int'(bus.paused), 0);
        rst = 1'b0;

        // Start: ch1 runs CCW independently, ch0 CW with soft start to duty 8.
        bus.enable = 1'b1;
        set_ch(1, 2, 15);
        set_ch(0, 1, 8);
        cycle();
        chk("cw_in1", int'(bus.in1[0]), 1);
        chk("cw_in2", int'(bus.in2[0]), 0);
        run(3 * PERIOD);
        hi = 0;
        for (int k = 0; k < PERIOD; k++) begin
            cycle();
            if (bus.pwm[0]) hi++;
        end
        chk("duty8_hi", hi, 8 * PRESC);

        // Reversal: coast for exactly the dead-time, then CCW.
        set_ch(0, 2, 8);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (bus.in1[0] == 1'b0 && bus.in2[0] == 1'b0 && bus.pwm[0] == 1'b0) n++;
            else break;
        end
        chk("dead_len", n, DEAD_CYC);
        chk("ccw_in2", int'(bus.in2[0]), 1);
        run(2 * PERIOD);

        // Dead-time cut short by brake, then brake straight to CW.
        set_ch(0, 1, 8);
        run(3);
        set_ch(0, 3, 8);
        cycle();
        chk("brake_pins", int'({bus.in1[0], bus.in2[0], bus.pwm[0]}), 7);
        set_ch(0, 1, 8);
        cycle();
        chk("brake_cw", int'({bus.in1[0], bus.in2[0]}), 2);
        run(2 * PERIOD);

        // Pause pulse, second pulse mid-pause must not extend it.
        bus.pause = 1'b1;
        cycle();
        chk("pause_lat", int'(bus.paused), 0);
        bus.pause = 1'b0;
        cycle();
        chk("pause_set", int'(bus.paused), 1);
        chk("pause_coast", int'({bus.in1, bus.in2, bus.pwm}), 0);
        n = 1;
        for (int k = 0; k < 100; k++) begin
            bus.pause = (n == 8);
            cycle();
            if (bus.paused) n++;
            else break;
        end
        bus.pause = 1'b0;
        chk("pause_len", n, PAUSE_CYC);
        run(3 * PERIOD);

        // Full duty, then immediate drop, then zero duty keeps direction.
        set_ch(0, 1, 15);
        run(5 * PERIOD);
        set_ch(0, 1, 3);
        run(PERIOD);
        set_ch(0, 1, 0);
        hi = 0;
        for (int k = 0; k < PERIOD; k++) begin
            cycle();
            if (bus.pwm[0] || !bus.in1[0]) hi++;
        end
        chk("duty0_quiet", hi, 0);

        // Asynchronous reset while ch0 PWM is high.
        set_ch(0, 1, 8);
        run(3 * PERIOD);
        found = 1'b0;
        for (int k = 0; k < 2 * PERIOD; k++) begin
            cycle();
            if (bus.pwm[0]) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_wait", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_pins", int'({bus.in1, bus.in2, bus.pwm}), 0);
        chk("arst_stby", int'(bus.stby), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run(PERIOD);

        // Random commands, pauses and enable toggles.
        for (int c = 0; c < 1500; c++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if ($urandom_range(0, 19) == 0) bus.dir_cmd[2*ch +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 39) == 0) bus.duty_cmd[PWM_W*ch +: PWM_W] = PWM_W'($urandom_range(0, STEPS - 1));
            end
            bus.pause = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 199) == 0) bus.enable = ~bus.enable;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
